// File: rtl/ofdm_rx_deframer.sv
// ofdm_rx_deframer: rebuilds and validates the 24-bit SIGNAL header, drops the
// SERVICE bits, packs LENGTH PSDU bytes LSB-first and flags the end of each frame.
module ofdm_rx_deframer #(
  parameter int SERVICE_BITS = 16,
  parameter int TIMEOUT      = 4096
) (
  input  logic        clk_In,
  input  logic        rstn_In,
  input  logic        di_signal,
  input  logic        di_signal_vld,
  input  logic        di_payload,
  input  logic        di_payload_vld,
  output logic [3:0]  do_rate,
  output logic [11:0] do_length,
  output logic        do_hdr_vld,
  output logic        do_hdr_err,
  output logic [7:0]  do_byte,
  output logic        do_byte_vld,
  output logic        do_frame_end,
  output logic        do_frame_err
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [15:0]   SVC_LAST  = 16'(SERVICE_BITS - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, HDR, SVC, DATA, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [22:0]   hdr_q, hdr_d;          // bits 0..22; bit 23 is taken straight off the wire
  logic [4:0]    hdr_cnt_q, hdr_cnt_d;
  logic [15:0]   bit_cnt_q, bit_cnt_d;
  logic [11:0]   byte_cnt_q, byte_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]    byte_sr_q, byte_sr_d;
  logic [3:0]    rate_q, rate_d;
  logic [11:0]   length_q, length_d;
  logic          hdr_vld_q, hdr_vld_d, hdr_err_q, hdr_err_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_vld_q, byte_vld_d, fend_q, fend_d, ferr_q, ferr_d;

  logic [23:0] hdr_full;
  logic        rate_ok, hdr_bad, in_frame, hdr_last, pay, svc_done, byte_done, last_byte, tmo;

  assign hdr_full  = {di_signal, hdr_q};
  assign in_frame  = (state_q == SVC) || (state_q == DATA);
  assign hdr_last  = (state_q == HDR) && di_signal_vld && (hdr_cnt_q == 5'd23);
  // SIGNAL wins over a coincident payload bit
  assign pay       = di_payload_vld && !di_signal_vld;
  assign svc_done  = (state_q == SVC) && pay && (bit_cnt_q == SVC_LAST);
  assign byte_done = (state_q == DATA) && pay && (bit_cnt_q[2:0] == 3'd7);
  assign last_byte = byte_done && ((byte_cnt_q + 12'd1) == length_q);
  assign tmo       = in_frame && !di_signal_vld && !di_payload_vld && (idle_cnt_q == IDLE_LAST);

  // Legal RATE codes, written as {R4,R3,R2,R1}
  always_comb begin
    case (hdr_full[3:0])
      4'b1011, 4'b1111, 4'b1010, 4'b1110,
      4'b1001, 4'b1101, 4'b1000, 4'b1100: rate_ok = 1'b1;
      default:                            rate_ok = 1'b0;
    endcase
  end

  // Header rejection: bad rate, reserved set, parity wrong, tail nonzero or zero length
  assign hdr_bad = !rate_ok || hdr_full[4] || (hdr_full[17] != ^hdr_full[16:0]) ||
                   (|hdr_full[23:18]) || (hdr_full[16:5] == 12'd0);

  // State register
  always_ff @(posedge clk_In or negedge rstn_In) begin
    if (!rstn_In) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DRAIN: if (di_signal_vld) state_d = HDR;
      HDR:         if (hdr_last) state_d = hdr_bad ? IDLE : ((SERVICE_BITS == 0) ? DATA : SVC);
      SVC: begin
        if (di_signal_vld) state_d = HDR;
        else if (tmo)      state_d = IDLE;
        else if (svc_done) state_d = DATA;
      end
      DATA: begin
        if (di_signal_vld)  state_d = HDR;
        else if (tmo)       state_d = IDLE;
        else if (last_byte) state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next-state
  always_comb begin
    hdr_d      = hdr_q;
    hdr_cnt_d  = hdr_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    byte_sr_d  = byte_sr_q;
    rate_d     = rate_q;
    length_d   = length_q;
    hdr_err_d  = hdr_err_q;
    byte_d     = byte_q;
    ferr_d     = ferr_q;
    hdr_vld_d  = 1'b0;
    byte_vld_d = 1'b0;
    fend_d     = 1'b0;
    if (di_signal_vld) begin
      if (state_q == HDR) begin
        if (hdr_cnt_q != 5'd23) hdr_d[hdr_cnt_q] = di_signal;
        hdr_cnt_d = hdr_cnt_q + 5'd1;
        if (hdr_last) begin
          rate_d     = hdr_full[3:0];
          length_d   = hdr_full[16:5];
          hdr_err_d  = hdr_bad;
          hdr_vld_d  = 1'b1;
          hdr_cnt_d  = 5'd0;
          bit_cnt_d  = 16'd0;
          byte_cnt_d = 12'd0;
          idle_cnt_d = '0;
        end
      end else begin
        // A new header always restarts collection; an open frame is aborted
        hdr_d     = {22'd0, di_signal};
        hdr_cnt_d = 5'd1;
        if (in_frame) begin
          fend_d = 1'b1;
          ferr_d = 1'b1;
        end
      end
    end else if (in_frame) begin
      if (di_payload_vld) begin
        idle_cnt_d = '0;
        if (state_q == SVC) begin
          bit_cnt_d = svc_done ? 16'd0 : bit_cnt_q + 16'd1;
        end else begin
          byte_sr_d[bit_cnt_q[2:0]] = di_payload;
          bit_cnt_d = bit_cnt_q + 16'd1;
          if (byte_done) begin
            byte_d     = byte_sr_d;
            byte_vld_d = 1'b1;
            byte_cnt_d = byte_cnt_q + 12'd1;
            if (last_byte) begin
              fend_d = 1'b1;
              ferr_d = 1'b0;
            end
          end
        end
      end else if (tmo) begin
        idle_cnt_d = '0;
        fend_d     = 1'b1;
        ferr_d     = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_In or negedge rstn_In) begin
    if (!rstn_In) begin
      hdr_q      <= '0;
      hdr_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      byte_sr_q  <= '0;
      rate_q     <= '0;
      length_q   <= '0;
      hdr_vld_q  <= 1'b0;
      hdr_err_q  <= 1'b0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      fend_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      hdr_q      <= hdr_d;
      hdr_cnt_q  <= hdr_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      byte_sr_q  <= byte_sr_d;
      rate_q     <= rate_d;
      length_q   <= length_d;
      hdr_vld_q  <= hdr_vld_d;
      hdr_err_q  <= hdr_err_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      fend_q     <= fend_d;
      ferr_q     <= ferr_d;
    end
  end

  assign do_rate      = rate_q;
  assign do_length    = length_q;
  assign do_hdr_vld   = hdr_vld_q;
  assign do_hdr_err   = hdr_err_q;
  assign do_byte      = byte_q;
  assign do_byte_vld  = byte_vld_q;
  assign do_frame_end = fend_q;
  assign do_frame_err = ferr_q;

endmodule

// File: tb/tb_ofdm_rx_deframer.sv
// tb_ofdm_rx_deframer: directed frames; expected events queued by stimulus,
// checked in order by an independent output monitor.
module tb_ofdm_rx_deframer;

  logic        clk_In = 1'b0;
  logic        rstn_In = 1'b0;
  logic        di_signal = 1'b0, di_signal_vld = 1'b0;
  logic        di_payload = 1'b0, di_payload_vld = 1'b0;
  logic [3:0]  do_rate;
  logic [11:0] do_length;
  logic        do_hdr_vld, do_hdr_err;
  logic [7:0]  do_byte;
  logic        do_byte_vld, do_frame_end, do_frame_err;

  ofdm_rx_deframer #(.SERVICE_BITS(16), .TIMEOUT(4096)) dut (
    .clk_In(clk_In), .rstn_In(rstn_In),
    .di_signal(di_signal), .di_signal_vld(di_signal_vld),
    .di_payload(di_payload), .di_payload_vld(di_payload_vld),
    .do_rate(do_rate), .do_length(do_length),
    .do_hdr_vld(do_hdr_vld), .do_hdr_err(do_hdr_err),
    .do_byte(do_byte), .do_byte_vld(do_byte_vld),
    .do_frame_end(do_frame_end), .do_frame_err(do_frame_err)
  );

  always #5 clk_In = ~clk_In;

  // kind: 0 = header {err,rate,length}, 1 = byte, 2 = frame end (err)
  typedef struct {int kind; logic [31:0] val;} exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endfunction

  function automatic void push(input int kind, input logic [31:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_hdr(input logic [3:0] rate, input logic [11:0] len, input logic err);
    push(0, {15'd0, err, rate, len});
  endfunction

  function automatic void pop_cmp(input int kind, input logic [31:0] got, input string name);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: unexpected event value %0h, nothing expected", name, got);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== got) begin
        n_bad++;
        $display("FAIL %s: got kind %0d value %0h expected kind %0d value %0h",
                 name, kind, got, e.kind, e.val);
      end
    end
  endfunction

  // Monitor: samples away from the active edge
  initial begin
    forever begin
      @(negedge clk_In);
      if (do_hdr_vld)   pop_cmp(0, {15'd0, do_hdr_err, do_rate, do_length}, "hdr");
      if (do_byte_vld)  pop_cmp(1, {24'd0, do_byte}, "byte");
      if (do_frame_end) pop_cmp(2, {31'd0, do_frame_err}, "frame_end");
    end
  end

  task automatic drive(input logic sv, input logic s, input logic pv, input logic p);
    @(negedge clk_In);
    di_signal_vld = sv; di_signal = s; di_payload_vld = pv; di_payload = p;
    @(posedge clk_In);
    #1;
    di_signal_vld = 1'b0; di_payload_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_In);
  endtask

  // rate is {R4,R3,R2,R1}; bit 0 optionally coincides with a payload bit
  task automatic send_header(input logic [3:0] rate, input logic [11:0] len, input bit flip_par,
                             input bit rsv, input logic [5:0] tail, input bit with_pay);
    logic [23:0] h;
    h = '0;
    h[3:0]   = rate;
    h[4]     = rsv;
    h[16:5]  = len;
    h[17]    = (^h[16:0]) ^ flip_par;
    h[23:18] = tail;
    for (int k = 0; k < 24; k++) drive(1'b1, h[k], (k == 0) && with_pay, 1'b1);
  endtask

  task automatic pay_bit(input logic b, input int maxgap);
    if (maxgap > 0) idle($urandom_range(0, maxgap));
    drive(1'b0, 1'b0, 1'b1, b);
  endtask

  task automatic send_bits(input logic [7:0] v, input int nbits, input int maxgap);
    for (int i = 0; i < nbits; i++) pay_bit(v[i], maxgap);
  endtask

  task automatic send_svc(input int maxgap);
    for (int i = 0; i < 16; i++) pay_bit(i[0], maxgap);
  endtask

  initial begin
    // Reset state
    idle(3);
    check("reset_outputs", {17'd0, do_rate, do_length, do_hdr_vld, do_hdr_err, do_byte,
                            do_byte_vld, do_frame_end, do_frame_err}, 32'd0);
    rstn_In = 1'b1;
    idle(2);

    // Good header, 3 bytes, pad ignored
    exp_hdr(4'b1011, 12'd3, 1'b0);
    push(1, 32'hA5); push(1, 32'h3C); push(1, 32'hFF); push(2, 32'd0);
    send_header(4'b1011, 12'd3, 0, 0, 6'd0, 0);
    send_svc(0);
    send_bits(8'hA5, 8, 0); send_bits(8'h3C, 8, 0); send_bits(8'hFF, 8, 0);
    send_bits(8'h5A, 8, 0); send_bits(8'h01, 2, 0);
    check("byte_hold", {24'd0, do_byte}, 32'hFF);
    idle(3);

    // Corrupted headers: no bytes may follow
    exp_hdr(4'b1011, 12'd3, 1'b1);
    send_header(4'b1011, 12'd3, 1, 0, 6'd0, 0);
    for (int i = 0; i < 5; i++) send_bits(8'h6B, 8, 0);
    exp_hdr(4'b0000, 12'd3, 1'b1);
    send_header(4'b0000, 12'd3, 0, 0, 6'd0, 0);
    for (int i = 0; i < 5; i++) send_bits(8'hC9, 8, 0);
    check("hdr_err_level", {31'd0, do_hdr_err}, 32'd1);
    exp_hdr(4'b1011, 12'd0, 1'b1);
    send_header(4'b1011, 12'd0, 0, 0, 6'd0, 0);
    send_bits(8'hFF, 8, 0);
    exp_hdr(4'b1110, 12'd2, 1'b1);
    send_header(4'b1110, 12'd2, 0, 1, 6'd0, 0);
    send_bits(8'hFF, 8, 0);
    exp_hdr(4'b1110, 12'd2, 1'b1);
    send_header(4'b1110, 12'd2, 0, 0, 6'd4, 0);
    send_bits(8'hFF, 8, 0);
    idle(3);

    // Gapped payload
    exp_hdr(4'b1111, 12'd2, 1'b0);
    push(1, 32'h5A); push(1, 32'hC3); push(2, 32'd0);
    send_header(4'b1111, 12'd2, 0, 0, 6'd0, 0);
    send_svc(20);
    send_bits(8'h5A, 8, 20); send_bits(8'hC3, 8, 20);
    send_bits(8'h00, 4, 20);
    idle(3);

    // Timeout after 11 PSDU bits; partial byte never strobed
    exp_hdr(4'b1001, 12'd2, 1'b0);
    push(1, 32'h96); push(2, 32'd1);
    send_header(4'b1001, 12'd2, 0, 0, 6'd0, 0);
    send_svc(20);
    send_bits(8'h96, 8, 20); send_bits(8'h07, 3, 20);
    idle(4110);
    check("after_timeout_err", {31'd0, do_frame_err}, 32'd1);

    // New SIGNAL mid-frame, coincident with a payload bit
    exp_hdr(4'b1101, 12'd5, 1'b0);
    push(1, 32'h11); push(2, 32'd1);
    exp_hdr(4'b1000, 12'd1, 1'b0);
    push(1, 32'h42); push(2, 32'd0);
    send_header(4'b1101, 12'd5, 0, 0, 6'd0, 0);
    send_svc(0);
    send_bits(8'h11, 8, 0);
    send_header(4'b1000, 12'd1, 0, 0, 6'd0, 1);
    send_svc(0);
    send_bits(8'h42, 8, 0);

    // Back-to-back: header starts in DRAIN right after frame end
    exp_hdr(4'b1100, 12'd1, 1'b0);
    push(1, 32'h81); push(2, 32'd0);
    send_header(4'b1100, 12'd1, 0, 0, 6'd0, 0);
    send_svc(0);
    send_bits(8'h81, 8, 0);
    send_bits(8'hFF, 6, 0);
    idle(3);

    // Reset mid-frame
    exp_hdr(4'b1010, 12'd4, 1'b0);
    push(1, 32'h5A);
    send_header(4'b1010, 12'd4, 0, 0, 6'd0, 0);
    send_svc(0);
    send_bits(8'h5A, 8, 0); send_bits(8'h05, 3, 0);
    @(negedge clk_In);
    #2 rstn_In = 1'b0;
    #1;
    check("async_reset_outputs", {17'd0, do_rate, do_length, do_hdr_vld, do_hdr_err, do_byte,
                                  do_byte_vld, do_frame_end, do_frame_err}, 32'd0);
    idle(5);
    rstn_In = 1'b1;
    exp_hdr(4'b1011, 12'd1, 1'b0);
    push(1, 32'hE7); push(2, 32'd0);
    send_header(4'b1011, 12'd1, 0, 0, 6'd0, 0);
    send_svc(0);
    send_bits(8'hE7, 8, 0);
    idle(10);

    check("pending_expected", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
